// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state type and address tables for the fetch sequencer.
// The top's optional cycle counter is enabled with FETCH_SEQ_CYCLE_COUNT_EN.
package fetch_pkg;

    localparam int FSEQ_W         = 10;
    localparam int FSEQ_NPROG     = 3;
    localparam int FSEQ_LUT_DEPTH = 16;
    localparam int FSEQ_IDX_W     = $clog2(FSEQ_LUT_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fseq_state_t;

    typedef logic [FSEQ_W-1:0] addr_t;

    localparam addr_t PROG_START [FSEQ_NPROG] = '{10'd0, 10'd144, 10'd400};
    localparam addr_t PROG_END   [FSEQ_NPROG] = '{10'd143, 10'd399, 10'd700};

    // Entry 2 (loop back to 4) and entry 5 (into program 2) are fixed by the programs.
    localparam addr_t JUMP_LUT [FSEQ_LUT_DEPTH] = '{
        10'd0,   10'd64,  10'd4,   10'd100,
        10'd200, 10'd410, 10'd150, 10'd300,
        10'd500, 10'd600, 10'd10,  10'd20,
        10'd30,  10'd144, 10'd400, 10'd1023
    };

endpackage

// File: rtl/jump_lut.sv
// jump_lut: combinational read of the absolute jump-target table.
module jump_lut
    import fetch_pkg::*;
(
    input  logic [FSEQ_IDX_W-1:0] idx,
    output logic [FSEQ_W-1:0]     target
);

    assign target = JUMP_LUT[idx];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-level PC controller (IDLE/LOAD/RUN/DONE).
// Define FETCH_SEQ_CYCLE_COUNT_EN to add the saturating CycleCnt output.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int W         = FSEQ_W,
    parameter int NPROG     = FSEQ_NPROG,
    parameter int LUT_DEPTH = FSEQ_LUT_DEPTH
) (
    input  logic                         CLK,
    input  logic                         Init_n,
    input  logic                         Start,
    input  logic [1:0]                   ProgSel,
    input  logic                         Stall,
    input  logic                         Branch,
    input  logic                         BTaken,
    input  logic [$clog2(LUT_DEPTH)-1:0] TargetIdx,
    output logic [W-1:0]                 PC,
    output logic                         Fetch_en,
    output logic                         Busy,
    output logic                         Halt,
    output logic                         Done,
    output logic                         Err
`ifdef FETCH_SEQ_CYCLE_COUNT_EN
    ,
    output logic [31:0]                  CycleCnt
`endif
);

    fseq_state_t state, state_d;
    logic [W-1:0] pc, pc_d;
    logic [1:0]   sel, sel_d;
    logic         err, err_d;
    logic [FSEQ_W-1:0] lut_target;
    logic         sel_ok;

    jump_lut u_jump_lut (
        .idx    (TargetIdx),
        .target (lut_target)
    );

    assign sel_ok = int'(ProgSel) < NPROG;

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state <= IDLE;
            pc    <= '0;
            sel   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            sel   <= sel_d;
            err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        sel_d   = sel;
        err_d   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Start && sel_ok) begin
                    sel_d   = ProgSel;
                    state_d = LOAD;
                end else if (Start) begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                pc_d    = W'(PROG_START[sel]);
                state_d = RUN;
            end
            RUN: begin
                // End check outranks any branch sitting on the last instruction.
                if (!Stall) begin
                    if (pc == W'(PROG_END[sel]))
                        state_d = DONE;
                    else
                        pc_d = (Branch && BTaken) ? W'(lut_target) : pc + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PC       = pc;
    assign Err      = err;
    assign Busy     = (state == LOAD) || (state == RUN);
    assign Halt     = state == DONE;
    assign Done     = state == DONE;
    assign Fetch_en = (state == RUN) && !Stall;

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
    logic [31:0] cnt;

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n)
            cnt <= '0;
        else if (state == LOAD)
            cnt <= '0;
        else if (state == RUN && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign CycleCnt = cnt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboarded random/directed bench for fetch_sequencer.
// Honours FETCH_SEQ_CYCLE_COUNT_EN to also check CycleCnt.
module tb_fetch_sequencer;

    logic       CLK = 1'b0;
    logic       Init_n = 1'b0;
    logic       Start = 1'b0, Stall = 1'b0, Branch = 1'b0, BTaken = 1'b0;
    logic [1:0] ProgSel = '0;
    logic [3:0] TargetIdx = '0;
    logic [9:0] PC;
    logic       Fetch_en, Busy, Halt, Done, Err;
    logic [31:0] cnt_obs;

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
    logic [31:0] CycleCnt;
    assign cnt_obs = CycleCnt;
`else
    assign cnt_obs = 32'd0;
`endif

    fetch_sequencer dut (
        .CLK       (CLK),
        .Init_n    (Init_n),
        .Start     (Start),
        .ProgSel   (ProgSel),
        .Stall     (Stall),
        .Branch    (Branch),
        .BTaken    (BTaken),
        .TargetIdx (TargetIdx),
        .PC        (PC),
        .Fetch_en  (Fetch_en),
        .Busy      (Busy),
        .Halt      (Halt),
        .Done      (Done),
        .Err       (Err)
`ifdef FETCH_SEQ_CYCLE_COUNT_EN
        ,
        .CycleCnt  (CycleCnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0]  pc;
        logic        fe, busy, halt, done, err;
        logic [31:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0;

    // Reference model: phase 0=idle, 1=loading, 2=running, 3=finished.
    int m_phase = 0, m_pc = 0, m_sel = 0;
    bit m_err = 0;
    longint m_cnt = 0;
    int starts [3] = '{0, 144, 400};
    int ends   [3] = '{143, 399, 700};
    int lut    [16] = '{0, 64, 4, 100, 200, 410, 150, 300, 500, 600, 10, 20, 30, 144, 400, 1023};

    function automatic obs_t expected(input bit stl);
        obs_t o;
        o.pc   = m_pc[9:0];
        o.fe   = (m_phase == 2) && !stl;
        o.busy = (m_phase == 1) || (m_phase == 2);
        o.halt = m_phase == 3;
        o.done = m_phase == 3;
        o.err  = m_err;
`ifdef FETCH_SEQ_CYCLE_COUNT_EN
        o.cnt  = m_cnt[31:0];
`else
        o.cnt  = 32'd0;
`endif
        return o;
    endfunction

    task automatic advance(input bit st, input int sel, input bit stl, br, tk, input int idx);
        bit e = 0;
        case (m_phase)
            0, 3: if (st) begin
                if (sel < 3) begin m_sel = sel; m_phase = 1; end
                else e = 1;
            end
            1: begin m_pc = starts[m_sel]; m_phase = 2; m_cnt = 0; end
            2: begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (!stl) begin
                    if (m_pc == ends[m_sel]) m_phase = 3;
                    else if (br && tk) m_pc = lut[idx];
                    else m_pc = (m_pc + 1) % 1024;
                end
            end
            default: ;
        endcase
        m_err = e;
    endtask

    task automatic step(input bit rst, st, input int sel, input bit stl, br, tk, input int idx);
        @(posedge CLK);
        #1;
        Init_n = rst; Start = st; ProgSel = 2'(sel); Stall = stl;
        Branch = br; BTaken = tk; TargetIdx = 4'(idx);
        if (!rst) begin
            m_phase = 0; m_pc = 0; m_sel = 0; m_err = 0; m_cnt = 0;
        end
        exp_q.push_back(expected(stl));
        if (rst) advance(st, sel, stl, br, tk, idx);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int pc, input int max);
        int k = 0;
        while (!(m_phase == 2 && m_pc == pc) && k < max) begin
            step(1, 0, 0, 0, 0, 0, 0);
            k++;
        end
        if (k >= max) begin
            tests++; fails++;
            $display("FAIL run_to: pc %0d not reached in %0d cycles (model pc=%0d)", pc, max, m_pc);
        end
    endtask

    task automatic run_done(input int max);
        int k = 0;
        while (m_phase != 3 && k < max) begin
            step(1, 0, 0, 0, 0, 0, 0);
            k++;
        end
        if (k >= max) begin
            tests++; fails++;
            $display("FAIL run_done: program did not finish in %0d cycles", max);
        end
    endtask

    always @(negedge CLK) begin
        obs_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{PC, Fetch_en, Busy, Halt, Done, Err, cnt_obs};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle %0d: got pc=%0d fe=%b busy=%b halt=%b done=%b err=%b cnt=%0d, want pc=%0d fe=%b busy=%b halt=%b done=%b err=%b cnt=%0d",
                         cyc, a.pc, a.fe, a.busy, a.halt, a.done, a.err, a.cnt,
                         e.pc, e.fe, e.busy, e.halt, e.done, e.err, e.cnt);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Program 0 straight through, then invalid restart from DONE.
        step(1, 1, 0, 0, 0, 0, 0);
        run_done(200);
        idle(2);
        step(1, 1, 3, 0, 0, 0, 0);
        idle(3);
        // Invalid select from IDLE.
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0);
        idle(3);
        // Branch taken / not taken at 20, stall at 50.
        step(1, 1, 0, 0, 0, 0, 0);
        run_to(20, 50);
        step(1, 0, 0, 0, 1, 1, 2);
        run_to(20, 50);
        step(1, 0, 0, 0, 1, 0, 2);
        run_to(50, 50);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 5);
        step(1, 0, 0, 1, 0, 0, 0);
        idle(2);
        run_done(200);
        // Restart program 2 from DONE; branch on the end instruction ignored.
        step(1, 1, 2, 0, 0, 0, 0);
        run_to(700, 400);
        step(1, 0, 0, 0, 1, 1, 2);
        idle(3);
        // Async reset mid-run at PC=77.
        step(1, 1, 0, 0, 0, 0, 0);
        run_to(77, 100);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Randomized traffic.
        repeat (25) begin
            int n;
            step(1, 1, int'($urandom_range(0, 3)), 0, 0, 0, 0);
            n = int'($urandom_range(20, 400));
            repeat (n) begin
                step(($urandom % 300) != 0, ($urandom % 50) == 0, int'($urandom_range(0, 3)),
                     ($urandom % 4) == 0, ($urandom % 6) == 0, $urandom % 2, int'($urandom % 16));
            end
        end
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
